siete_segmento_mux: RTL
=======================

// Module: siete_segmento_mux
// PURPOSE
//  Time-multiplexed driver for N_DIG common-anode 7-segment digits (hex 0-F).
//  Latches a packed nibble vector on a load strobe and scans one digit per refresh slot.
//  Adds optional leading-zero blanking, per-digit blink, per-digit decimal point and an
//  anode dead time between digits. Sits between dispenser control logic and the board display.
// PARAMETERS
//  N_DIG        4      number of digits, >=1; digit 0 = least significant (rightmost)
//  DIV          50000  clk cycles per digit slot, >=2
//  BLINK_FRAMES 64     complete scans per blink half-period, >=1
// PORTS
//  clk       in   1        system clock, all logic on rising edge
//  rst       in   1        synchronous, active-high reset
//  load      in   1        1-cycle strobe: capture value/dp_in into shadow registers
//  value     in   4*N_DIG  packed nibbles; digit i = value[4*i+3:4*i]
//  dp_in     in   N_DIG    decimal point request per digit, 1 = lit
//  blank_lz  in   1        1 = suppress leading zeros
//  blink_en  in   N_DIG    1 = digit i blinks
//  SSeg      out  7        segments {a,b,c,d,e,f,g}, active low
//  dp        out  1        decimal point, active low
//  an        out  N_DIG    digit enables, active low, at most one low
//  frame     out  1        1-cycle pulse at the end of each full scan
// BEHAVIOUR
//  - Reset: SSeg=7'h7F, dp=1, an=all 1, frame=0; prescaler, idx, blink counter, blink phase,
//    shadow and display registers = 0. Reset mid-scan aborts at once; scan restarts at digit 0.
//  - All outputs registered; no combinational path input->output.
//  - Prescaler pc: 0..DIV-1, wraps. At pc==DIV-1: idx <= (idx==N_DIG-1)?0:idx+1.
//    Widths: pc $clog2(DIV); idx max(1,$clog2(N_DIG)).
//  - Per slot, 2-state FSM: DEAD (pc==0: an all 1, SSeg=7'h7F, dp=1) -> DRIVE (pc 1..DIV-1:
//    an[idx]=0, SSeg/dp from disp[idx]). Dead time: exactly 1 clk per slot.
//  - load: shadow <= {value,dp_in} on the load edge. disp <= shadow only at the end of a scan
//    (pc==DIV-1 && idx==N_DIG-1). load on that same cycle: the new value goes straight to disp.
//    Display latency: frame-coherent, no mixed old/new digits within one scan.
//  - frame=1 for exactly the cycle after the last-digit wrap (coincident with idx=0, pc=0).
//  - Leading zeros (blank_lz=1): digit i blanked if disp nibbles N_DIG-1..i all 0 and i!=0.
//    Digit 0 is never suppressed; all-zero value shows a single "0". Blanked digit: an[i] stays 1.
//    dp_in of a blanked digit is also suppressed.
//  - Blink: counter of frames 0..BLINK_FRAMES-1; phase toggles on wrap. phase=1 && blink_en[i]
//    -> digit i blanked (an[i]=1). blink_en sampled live, not shadowed.
//  - Decode (active low, abcdefg): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000
//    C=0110001 d=1000010 E=0110000 F=0111000. Every nibble has a code; no default blank.
//  - N_DIG=1: idx fixed 0, frame every DIV cycles, blanking rule for leading zeros is a no-op.
// STRUCTURE
//  - Package siete_seg_pkg: SEG_OFF=7'h7F, 16-entry segment table constants,
//    function hex_a_7seg(nibble)->7 bits.
//  - Sub-module decodificador_7seg: combinational nibble -> SSeg using the package function;
//    one instance fed by the digit mux. Scan counter, FSM, blanking and registers in top.
// TESTING
//  1. rst held 3 cycles mid-scan -> SSeg=7F, dp=1, an=all 1 next edge; after release first
//     drive is digit 0 at pc=1.
//  2. DIV=4,N_DIG=4, load value=16'h12AF -> after next frame: an=1110 shows F(0111000),
//     1101 A, 1011 2, 0111 1; one all-high cycle between each.
//  3. blank_lz=1, value=16'h0030 -> digits 3,2 never enabled; digit1 "3", digit0 "0";
//     value=0 -> only digit0 "0".
//  4. load 16'h1111 mid-scan, then 16'h2222 on final cycle of scan -> 1111 never displayed,
//     2222 from next scan; no scan mixes values.
//  5. blink_en=4'b0100, BLINK_FRAMES=2 -> an[2] low for 2 frames, high for 2, repeating;
//     other digits unaffected; dp_in=4'b0001 -> dp=0 only while an[0]=0.
//  6. frame pulse width 1 clk, period N_DIG*DIV clks; check N_DIG=1 build as well.

Source files
------------

// File: rtl/siete_seg_pkg.sv
// rtl/siete_seg_pkg.sv - segment constants, hex decode table and scan FSM states
// Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment (common-anode display).
package siete_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Packed so that SEG_TABLE[n] is the code for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_a_7seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// rtl/decodificador_7seg.sv - combinational hex nibble to active-low segment decoder
module decodificador_7seg
    import siete_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_a_7seg(nibble_i);

endmodule

// File: rtl/siete_segmento_mux.sv
// rtl/siete_segmento_mux.sv - multiplexed N-digit 7-segment driver with blanking and blink
// Outputs are registered from next-state values so they line up with the scan counters.
module siete_segmento_mux
    import siete_seg_pkg::*;
#(
    parameter int N_DIG        = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [4*N_DIG-1:0] value,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic               blank_lz,
    input  logic [N_DIG-1:0]   blink_en,
    output logic [6:0]         SSeg,
    output logic               dp,
    output logic [N_DIG-1:0]   an,
    output logic               frame
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);
    localparam logic [BW-1:0] BC_LAST  = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]      pc_q, pc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BW-1:0]      bc_q, bc_d;
    logic               phase_q, phase_d;
    logic [4*N_DIG-1:0] shadow_val_q, shadow_val_d;
    logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*N_DIG-1:0] disp_val_q, disp_val_d;
    logic [N_DIG-1:0]   disp_dp_q, disp_dp_d;
    scan_state_e        state_q, state_d;
    logic [6:0]         sseg_q, sseg_d;
    logic               dp_q, dp_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               frame_q, frame_d;

    logic               slot_end;
    logic               scan_end;
    logic               lz_run;
    logic [N_DIG-1:0]   lz_blank;
    logic [3:0]         nib_sel;
    logic               dp_sel;
    logic               blank_sel;
    logic [6:0]         seg_dec;

    // Scan counters, blink phase and the shadow/display double buffer.
    always_comb begin
        slot_end = (pc_q == PC_LAST);
        scan_end = slot_end && (idx_q == IDX_LAST);
        pc_d     = slot_end ? '0 : pc_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        bc_d    = bc_q;
        phase_d = phase_q;
        if (scan_end) begin
            if (bc_q == BC_LAST) begin
                bc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end
        shadow_val_d = load ? value : shadow_val_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        // Using shadow_*_d lets a load on the last scan cycle reach the display directly.
        if (scan_end) begin
            disp_val_d = shadow_val_d;
            disp_dp_d  = shadow_dp_d;
        end
        frame_d = scan_end;
    end

    // Leading-zero mask scanned from the top digit down, then the digit mux.
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            lz_run      = lz_run && (disp_val_d[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz && lz_run && (i != 0);
        end
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_d == IW'(i)) begin
                nib_sel   = disp_val_d[4*i +: 4];
                dp_sel    = disp_dp_d[i];
                blank_sel = lz_blank[i] || (phase_d && blink_en[i]);
            end
        end
    end

    decodificador_7seg u_dec (
        .nibble_i (nib_sel),
        .seg_o    (seg_dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DEAD:  state_d = ST_DRIVE;
            ST_DRIVE: state_d = slot_end ? ST_DEAD : ST_DRIVE;
            default:  state_d = ST_DEAD;
        endcase
        an_d   = '1;
        sseg_d = SEG_OFF;
        dp_d   = 1'b1;
        if ((state_d == ST_DRIVE) && !blank_sel) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (idx_d == IW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            sseg_d = seg_dec;
            dp_d   = ~dp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            idx_q        <= '0;
            bc_q         <= '0;
            phase_q      <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            state_q      <= ST_DEAD;
            sseg_q       <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            bc_q         <= bc_d;
            phase_q      <= phase_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            state_q      <= state_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign SSeg  = sseg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
